// File: rtl/s_if_pkg.sv
// Shared serial-link definitions for the s_* transmitter/receiver pair.
// Frame length grows by one parity bit when S_RX_PARITY_EN is defined.
package s_if_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    localparam logic RB_READ  = 1'b1;
    localparam logic RB_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } s_rx_state_t;

    function automatic int frame_len(input int aw, input int dw);
`ifdef S_RX_PARITY_EN
        return aw + dw + 1;
`else
        return aw + dw;
`endif
    endfunction

endpackage

// File: rtl/s_rx_shift.sv
// Deframing datapath: MSB-first shift register, saturating bit counter,
// overlong flag and (with S_RX_PARITY_EN) an even-parity accumulator.
module s_rx_shift #(
    parameter int N = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         shift,
    input  logic         sd,
    output logic [N-1:0] sr,
    output logic         ok
);
    localparam int CW = $clog2(N + 2);

    logic [CW-1:0] cnt;
    logic          ovl;
    logic          cnt_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr  <= '0;
            cnt <= '0;
            ovl <= 1'b0;
        end else if (start) begin
            sr  <= {{(N-1){1'b0}}, sd};
            cnt <= CW'(1);
            ovl <= 1'b0;
        end else if (shift) begin
            sr <= {sr[N-2:0], sd};
            // Once a bit lands past position N the frame can never be valid.
            if (cnt == CW'(N))
                ovl <= 1'b1;
            if (cnt != CW'(N + 1))
                cnt <= cnt + 1'b1;
        end
    end

    assign cnt_ok = (cnt == CW'(N)) && !ovl;

`ifdef S_RX_PARITY_EN
    logic par;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            par <= 1'b0;
        else if (start)
            par <= sd;
        else if (shift)
            par <= par ^ sd;
    end

    assign ok = cnt_ok && !par;
`else
    assign ok = cnt_ok;
`endif

endmodule

// File: rtl/s_rx_rb.sv
// Serial receiver: deframes sen/sd address+data packets into RB2 writes and
// raises S_done after FRAMES valid writes. Optional parity via S_RX_PARITY_EN.
module s_rx_rb
    import s_if_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAMES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sen,
    input  logic              sd,
    output logic              S_done,
    output logic              RB_RW,
    output logic [ADDR_W-1:0] RB_A,
    output logic [DATA_W-1:0] RB_D,
    output logic              frame_err
);
    localparam int N   = frame_len(ADDR_W, DATA_W);
    localparam int FCW = $clog2(FRAMES + 1);

    s_rx_state_t    state;
    logic [FCW-1:0] frm_cnt;
    logic [N-1:0]   sr;
    logic           frame_ok;
    logic           last;
    logic           start;
    logic           shift;

    assign last  = (frm_cnt == FCW'(FRAMES));
    // WRITE doubles as the idle gap so a one-cycle sen-high separation suffices.
    assign start = !sen && ((state == IDLE) || ((state == WRITE) && !last));
    assign shift = !sen && (state == SHIFT);

    s_rx_shift #(.N(N)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .shift (shift),
        .sd    (sd),
        .sr    (sr),
        .ok    (frame_ok)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            frm_cnt   <= '0;
            S_done    <= 1'b0;
            RB_RW     <= RB_READ;
            RB_A      <= '0;
            RB_D      <= '0;
            frame_err <= 1'b0;
        end else begin
            RB_RW     <= RB_READ;
            frame_err <= 1'b0;
            case (state)
                IDLE: if (!sen) state <= SHIFT;
                SHIFT: if (sen) begin
                    if (frame_ok) begin
                        state   <= WRITE;
                        RB_RW   <= RB_WRITE;
                        RB_A    <= sr[N-1 -: ADDR_W];
                        RB_D    <= sr[N-ADDR_W-1 -: DATA_W];
                        frm_cnt <= frm_cnt + 1'b1;
                    end else begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end
                end
                WRITE: begin
                    if (last) begin
                        state  <= DONE;
                        S_done <= 1'b1;
                    end else if (!sen) begin
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE:    S_done <= 1'b1;
                default: state  <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s_rx_rb.sv
// Scoreboard bench for s_rx_rb: expected writes are queued as frames are sent
// and matched against RB_RW strobes observed on the falling edge.
module tb_s_rx_rb;
    localparam int AW = 5;
    localparam int DW = 8;
`ifdef S_RX_PARITY_EN
    localparam int N = AW + DW + 1;
`else
    localparam int N = AW + DW;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sen = 1'b1;
    logic          sd  = 1'b0;
    logic          S_done, RB_RW, frame_err;
    logic [AW-1:0] RB_A;
    logic [DW-1:0] RB_D;

    int checks  = 0;
    int errors  = 0;
    int strobes = 0;
    int errs    = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_e;
    logic [DW-1:0]    bank [0:31];

    always #5 clk = ~clk;

    s_rx_rb #(.ADDR_W(AW), .DATA_W(DW), .FRAMES(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .sen       (sen),
        .sd        (sd),
        .S_done    (S_done),
        .RB_RW     (RB_RW),
        .RB_A      (RB_A),
        .RB_D      (RB_D),
        .frame_err (frame_err)
    );

    always @(negedge clk) begin
        if (rst) begin
            if (RB_RW === 1'b0) begin
                strobes++;
                bank[RB_A] = RB_D;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got A=%h D=%h required no write", RB_A, RB_D);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({RB_A, RB_D} !== mon_e) begin
                        errors++;
                        $display("FAIL write_data got A=%h D=%h required A=%h D=%h",
                                 RB_A, RB_D, mon_e[AW+DW-1:DW], mon_e[DW-1:0]);
                    end
                end
            end
            if (frame_err === 1'b1) errs++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] frm(input logic [AW-1:0] a, input logic [DW-1:0] d);
`ifdef S_RX_PARITY_EN
        return {2'b0, a, d, ^{a, d}};
`else
        return {3'b0, a, d};
`endif
    endfunction

    task automatic drive_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sen = 1'b0;
            sd  = v[i];
            @(posedge clk); #1;
        end
        sen = 1'b1;
        sd  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sen = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({S_done, RB_RW, RB_A, RB_D, frame_err} !== {1'b0, 1'b1, 5'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got S_done=%b RB_RW=%b A=%h D=%h err=%b required 0 1 00 00 0",
                     S_done, RB_RW, RB_A, RB_D, frame_err);
        end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        int s0;
        v = frm(5'h03, 8'hA5);
        for (int i = N - 1; i >= N - 6; i--) begin
            sen = 1'b0;
            sd  = v[i];
            @(posedge clk); #1;
        end
        rst = 1'b0;
        sen = 1'b1;
        #1;
        checks++;
        if ({S_done, RB_RW, RB_A, RB_D, frame_err} !== {1'b0, 1'b1, 5'h00, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_values got S_done=%b RB_RW=%b A=%h D=%h err=%b required 0 1 00 00 0",
                     S_done, RB_RW, RB_A, RB_D, frame_err);
        end
        @(posedge clk); #1 rst = 1'b1;
        s0 = strobes;
        exp_q.push_back({5'h03, 8'hA5});
        drive_bits(v, N);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({RB_RW, RB_A, RB_D} !== {1'b0, 5'h03, 8'hA5}) begin
            errors++;
            $display("FAIL after_reset_write got RW=%b A=%h D=%h required 0 03 a5", RB_RW, RB_A, RB_D);
        end
        @(negedge clk);
        checks++;
        if (strobes - s0 != 1) begin
            errors++;
            $display("FAIL after_reset_strobes got %0d required 1", strobes - s0);
        end
    endtask

    task automatic test_single();
        int s0;
        s0 = strobes;
        exp_q.push_back({5'h1F, 8'h3C});
        drive_bits(frm(5'h1F, 8'h3C), N);
        @(negedge clk);
        checks++;
        if (RB_RW !== 1'b1) begin
            errors++;
            $display("FAIL single_early got RB_RW=%b required 1", RB_RW);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({RB_RW, frame_err} !== 2'b00) begin
            errors++;
            $display("FAIL single_strobe got RW=%b err=%b required 0 0", RB_RW, frame_err);
        end
        @(negedge clk);
        checks++;
        if ({RB_RW, frame_err, RB_A, RB_D} !== {1'b1, 1'b0, 5'h1F, 8'h3C}) begin
            errors++;
            $display("FAIL single_after got RW=%b err=%b A=%h D=%h required 1 0 1f 3c",
                     RB_RW, frame_err, RB_A, RB_D);
        end
        checks++;
        if (strobes - s0 != 1) begin
            errors++;
            $display("FAIL single_count got %0d required 1", strobes - s0);
        end
    endtask

    task automatic test_bad_frames();
        int s0, e0;
        s0 = strobes;
        e0 = errs;
        drive_bits(frm(5'h0A, 8'h55), N - 1);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL short_err got %b required 1", frame_err);
        end
        @(posedge clk); #1;
        drive_bits(16'hFFFF, N + 1);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({frame_err, RB_RW} !== 2'b11) begin
            errors++;
            $display("FAIL long_err got err=%b RW=%b required 1 1", frame_err, RB_RW);
        end
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_width got %b required 0", frame_err);
        end
        checks++;
        if (errs - e0 != 2 || strobes != s0 || S_done !== 1'b0) begin
            errors++;
            $display("FAIL bad_summary got errs=%0d strobes=%0d S_done=%b required 2 0 0",
                     errs - e0, strobes - s0, S_done);
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        do_reset();
        for (int i = 0; i < 32; i++) bank[i] = 'x;
        s0 = strobes;
        for (int i = 0; i < 32; i++) begin
            a = AW'(i);
            d = 8'(255 - i);
            exp_q.push_back({a, d});
            drive_bits(frm(a, d), N);
            if (i < 31) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({RB_RW, S_done} !== 2'b00) begin
            errors++;
            $display("FAIL last_strobe got RW=%b S_done=%b required 0 0", RB_RW, S_done);
        end
        @(negedge clk);
        checks++;
        if ({RB_RW, S_done} !== 2'b11) begin
            errors++;
            $display("FAIL done_rise got RW=%b S_done=%b required 1 1", RB_RW, S_done);
        end
        checks++;
        if (strobes - s0 != 32) begin
            errors++;
            $display("FAIL b2b_count got %0d required 32", strobes - s0);
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (bank[i] !== 8'(255 - i)) begin
                errors++;
                $display("FAIL bank[%0d] got %h required %h", i, bank[i], 8'(255 - i));
            end
        end
        @(posedge clk); #1;
        drive_bits(frm(5'h05, 8'h77), N);
        repeat (4) @(negedge clk);
        checks++;
        if (strobes - s0 != 32 || {S_done, RB_RW, RB_A, RB_D, frame_err} !== {1'b1, 1'b1, 5'h1F, 8'hE0, 1'b0}) begin
            errors++;
            $display("FAIL frame33 got strobes=%0d S_done=%b RW=%b A=%h D=%h err=%b required 32 1 1 1f e0 0",
                     strobes - s0, S_done, RB_RW, RB_A, RB_D, frame_err);
        end
    endtask

`ifdef S_RX_PARITY_EN
    task automatic test_parity();
        int s0;
        do_reset();
        s0 = strobes;
        exp_q.push_back({5'h01, 8'h01});
        drive_bits(frm(5'h01, 8'h01), N);
        @(posedge clk); #1;
        drive_bits(frm(5'h01, 8'h01) ^ 16'h0001, N);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({frame_err, RB_RW} !== 2'b11) begin
            errors++;
            $display("FAIL parity_err got err=%b RW=%b required 1 1", frame_err, RB_RW);
        end
        @(negedge clk);
        checks++;
        if (strobes - s0 != 1) begin
            errors++;
            $display("FAIL parity_count got %0d required 1", strobes - s0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid();
        test_single();
        test_bad_frames();
        test_back_to_back();
`ifdef S_RX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_writes got %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
